// File: rtl/shot_scorer.sv
`default_nettype none
// ============================================================================
// Module   : shot_scorer
// Purpose  : Samples the ball position once per frame and decides whether each
//            shot is a MAKE or a MISS. A make is a downward crossing of the rim
//            plane inside the hoop window. Keeps a saturating 2-digit BCD score
//            and emits one-cycle result pulses for the display and SFX logic.
// Ports    : CLK100MHZ   in   1   system clock
//            rst_n       in   1   async active-low reset
//            frame_tick  in   1   one pulse per frame, position sample strobe
//            ball_x      in  10   ball centre x
//            ball_y      in  10   ball centre y (grows downward)
//            shot_start  in   1   pulse, shot launched
//            shot_abort  in   1   level, shot clock expired / manual reset
//            clear_score in   1   pulse, zero the score
//            score_bcd   out  8   {tens,ones} BCD score
//            make_pulse  out  1   one cycle on a made shot
//            miss_pulse  out  1   one cycle on a missed or aborted shot
//            in_flight   out  1   high while a shot is being tracked
//            last_pts    out  2   points of the last make, 0 after a miss
// Revision : 1.0  initial release
// ============================================================================
module shot_scorer #(
    parameter logic [9:0] RIM_Y       = 10'd180,
    parameter logic [9:0] HOOP_X_MIN  = 10'd540,
    parameter logic [9:0] HOOP_X_MAX  = 10'd580,
    parameter logic [9:0] FLOOR_Y     = 10'd470,
    parameter logic [9:0] SCREEN_W    = 10'd640,
    parameter logic [9:0] THREE_PT_X  = 10'd200,
    parameter logic [8:0] MAX_FRAMES  = 9'd300,
    parameter logic [6:0] HOLD_FRAMES = 7'd60
) (
    input  logic       CLK100MHZ,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic       shot_start,
    input  logic       shot_abort,
    input  logic       clear_score,
    output logic [7:0] score_bcd,
    output logic       make_pulse,
    output logic       miss_pulse,
    output logic       in_flight,
    output logic [1:0] last_pts
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_TRACK  = 3'd1;
    localparam logic [2:0] S_MAKE   = 3'd2;
    localparam logic [2:0] S_MISS   = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    logic [2:0] state;
    logic [2:0] next_state;
    logic [1:0] pts;
    logic [9:0] prev_y;
    logic [8:0] frame_cnt;
    logic [6:0] hold_cnt;

    logic       hit_make;
    logic       hit_miss;
    logic       make_d;
    logic       miss_d;
    logic       flight_d;

    logic [4:0] ones_sum;
    logic [4:0] ones_adj;
    logic       carry;
    logic [7:0] score_sum;

    // Only a top-to-bottom crossing counts; prev_y holds the last sample.
    assign hit_make = (prev_y < RIM_Y) && (ball_y >= RIM_Y) &&
                      (ball_x >= HOOP_X_MIN) && (ball_x <= HOOP_X_MAX);
    assign hit_miss = (ball_y >= FLOOR_Y) || (ball_x >= SCREEN_W) ||
                      (frame_cnt == MAX_FRAMES - 9'd1);

    // State register
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (shot_start && !shot_abort) next_state = S_TRACK;
            end
            S_TRACK: begin
                // Abort is honoured on any cycle, ahead of the frame checks.
                if (shot_abort) begin
                    next_state = S_MISS;
                end else if (frame_tick) begin
                    if (hit_make)      next_state = S_MAKE;
                    else if (hit_miss) next_state = S_MISS;
                end
            end
            S_MAKE, S_MISS: begin
                next_state = S_RESULT;
            end
            S_RESULT: begin
                if (shot_abort) begin
                    next_state = S_IDLE;
                end else if (frame_tick && (hold_cnt == HOLD_FRAMES - 7'd1)) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered below so the pulses
    // land in the MAKE/MISS cycle and in_flight tracks TRACK glitch-free.
    always_comb begin
        make_d   = (next_state == S_MAKE);
        miss_d   = (next_state == S_MISS);
        flight_d = (next_state == S_TRACK);
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            make_pulse <= 1'b0;
            miss_pulse <= 1'b0;
            in_flight  <= 1'b0;
        end else begin
            make_pulse <= make_d;
            miss_pulse <= miss_d;
            in_flight  <= flight_d;
        end
    end

    // BCD add of pts with saturation at 99.
    always_comb begin
        ones_sum = {1'b0, score_bcd[3:0]} + {3'b000, pts};
        ones_adj = ones_sum - 5'd10;
        carry    = (ones_sum > 5'd9);
        if (carry && (score_bcd[7:4] == 4'd9)) begin
            score_sum = 8'h99;
        end else if (carry) begin
            score_sum = {score_bcd[7:4] + 4'd1, ones_adj[3:0]};
        end else begin
            score_sum = {score_bcd[7:4], ones_sum[3:0]};
        end
    end

    // Shot datapath and score. The score moves on the same edge that enters
    // MAKE, so it changes together with make_pulse and a clear in the deciding
    // cycle overrides the add.
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            pts       <= 2'd0;
            prev_y    <= 10'd0;
            frame_cnt <= 9'd0;
            hold_cnt  <= 7'd0;
            score_bcd <= 8'h00;
            last_pts  <= 2'd0;
        end else begin
            if ((state == S_IDLE) && (next_state == S_TRACK)) begin
                pts       <= (ball_x < THREE_PT_X) ? 2'd3 : 2'd2;
                prev_y    <= ball_y;
                frame_cnt <= 9'd0;
            end else if ((state == S_TRACK) && (next_state == S_TRACK) && frame_tick) begin
                prev_y    <= ball_y;
                frame_cnt <= frame_cnt + 9'd1;
            end

            if ((state == S_MAKE) || (state == S_MISS)) begin
                hold_cnt <= 7'd0;
            end else if ((state == S_RESULT) && frame_tick) begin
                hold_cnt <= hold_cnt + 7'd1;
            end

            if (state == S_TRACK) begin
                if (next_state == S_MAKE)      last_pts <= pts;
                else if (next_state == S_MISS) last_pts <= 2'd0;
            end

            if (clear_score) begin
                score_bcd <= 8'h00;
            end else if ((state == S_TRACK) && (next_state == S_MAKE)) begin
                score_bcd <= score_sum;
            end
        end
    end

endmodule
`default_nettype wire
